// File: rtl/expr_pipe_alu.sv
// Two-stage, NCH-channel SIMD ALU with valid/ready handshaking.
// Each channel has its own accumulator, and add/sub/acc can either wrap or saturate.
module expr_pipe_alu #(
  parameter int W   = 6,
  parameter int NCH = 3,
  parameter int SAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [NCH*W-1:0] a,
  input  logic [NCH*W-1:0] b,
  input  logic [NCH-1:0]   a_signed,
  input  logic [NCH-1:0]   b_signed,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NCH*W-1:0] y,
  output logic [NCH-1:0]   ovf
);

  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [NCH*W-1:0] r_s1_a;
  logic [NCH*W-1:0] r_s1_b;
  logic [NCH-1:0]   r_s1_as;
  logic [NCH-1:0]   r_s1_bs;
  logic             r_out_valid;
  logic [NCH*W-1:0] r_y;
  logic [NCH-1:0]   r_ovf;
  logic [W-1:0]     r_acc [NCH];

  logic             w_en;
  logic [W:0]       w_res [NCH];

  function automatic logic [W:0] ext(input logic [W-1:0] x, input logic s);
    return s ? {x[W-1], x} : {1'b0, x};
  endfunction

  // Returns {overflow, result}; bit W of the W+1-bit sum is the true sign/borrow.
  function automatic logic [W:0] addSub(input logic [W-1:0] x, input logic [W-1:0] z,
                                        input logic s, input logic sub);
    logic [W:0]   t;
    logic         o;
    logic [W-1:0] r;
    t = sub ? (ext(x, s) - ext(z, s)) : (ext(x, s) + ext(z, s));
    o = s ? (t[W] ^ t[W-1]) : t[W];
    r = t[W-1:0];
    if (SAT != 0 && o) begin
      if (s)
        r = t[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
        r = sub ? '0 : '1;
    end
    return {o, r};
  endfunction

  function automatic logic [W:0] chan(input logic [2:0] opc, input logic [W-1:0] x,
                                      input logic [W-1:0] z, input logic as,
                                      input logic bs, input logic [W-1:0] accv);
    logic         s;
    logic [2:0]   sh;
    logic         lt;
    logic [W-1:0] sr;
    logic [W:0]   res;
    s   = as && bs;
    sh  = z[2:0];
    lt  = s ? ($signed(x) < $signed(z)) : (x < z);
    sr  = $signed(x) >>> sh;
    res = '0;
    case (opc)
      3'd0: res = addSub(x, z, s, 1'b0);
      3'd1: res = addSub(x, z, s, 1'b1);
      3'd2: res = {1'b0, x & z};
      3'd3: res = {1'b0, ~(x ^ z)};
      3'd4: res = {{W{1'b0}}, lt};
      3'd5: res = {1'b0, x << sh};
      3'd6: res = as ? {1'b0, sr} : {1'b0, x >> sh};
      default: res = addSub(accv, x, s, 1'b0);
    endcase
    return res;
  endfunction

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // A clear in the same cycle as an accumulate makes the beat start from zero.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_res[k] = chan(r_s1_op, r_s1_a[k*W +: W], r_s1_b[k*W +: W], r_s1_as[k],
                      r_s1_bs[k], acc_clr ? '0 : r_acc[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_ovf       <= '0;
      for (int k = 0; k < NCH; k++) r_acc[k] <= '0;
    end else begin
      if (w_en) begin
        r_s1_valid  <= in_valid;
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          for (int k = 0; k < NCH; k++) begin
            r_y[k*W +: W] <= w_res[k][W-1:0];
            r_ovf[k]      <= w_res[k][W];
          end
        end
      end
      for (int k = 0; k < NCH; k++) begin
        if (w_en && r_s1_valid && r_s1_op == 3'd7)
          r_acc[k] <= w_res[k][W-1:0];
        else if (acc_clr)
          r_acc[k] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_en && in_valid) begin
      r_s1_op <= op;
      r_s1_a  <= a;
      r_s1_b  <= b;
      r_s1_as <= a_signed;
      r_s1_bs <= b_signed;
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_expr_pipe_alu.sv
// Directed bench for expr_pipe_alu: wrapping (SAT=0) and saturating (SAT=1) copies
// driven by the same stimulus, each checked against hand-computed results.
module tb_expr_pipe_alu;

  typedef logic [2:0][5:0] bus_t;

  typedef struct {
    string      name;
    logic [2:0] op;
    bus_t       a;
    bus_t       b;
    logic [2:0] as;
    logic [2:0] bs;
    bus_t       y0;
    logic [2:0] o0;
    bus_t       y1;
    logic [2:0] o1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, in_valid, acc_clr, out_ready;
  logic [2:0] op;
  bus_t       a, b;
  logic [2:0] a_signed, b_signed;
  logic       in_ready0, in_ready1, out_valid0, out_valid1;
  logic [17:0] y0s, y1s;
  logic [2:0]  ovf0s, ovf1s;

  int checks   = 0;
  int failures = 0;

  vec_t vecs [9];
  vec_t v;

  expr_pipe_alu #(.W(6), .NCH(3), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .op(op),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .acc_clr(acc_clr),
    .out_valid(out_valid0), .out_ready(out_ready), .y(y0s), .ovf(ovf0s));

  expr_pipe_alu #(.W(6), .NCH(3), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .acc_clr(acc_clr),
    .out_valid(out_valid1), .out_ready(out_ready), .y(y1s), .ovf(ovf1s));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkBoth(input string name, input bus_t e0, input logic [2:0] eo0,
                           input bus_t e1, input logic [2:0] eo1);
    checkOutput({name, "/valid0"}, 32'(out_valid0), 32'd1);
    checkOutput({name, "/y0"}, 32'(y0s), 32'(e0));
    checkOutput({name, "/ovf0"}, 32'(ovf0s), 32'(eo0));
    checkOutput({name, "/valid1"}, 32'(out_valid1), 32'd1);
    checkOutput({name, "/y1"}, 32'(y1s), 32'(e1));
    checkOutput({name, "/ovf1"}, 32'(ovf1s), 32'(eo1));
  endtask

  // One beat through an otherwise idle pipe; acc_clr optionally pulsed as it enters S2.
  task automatic applyStimulus(input vec_t t, input bit clrAtAdvance);
    @(negedge clk);
    in_valid = 1'b1; op = t.op; a = t.a; b = t.b;
    a_signed = t.as; b_signed = t.bs; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; acc_clr = clrAtAdvance;
    @(posedge clk);
    @(negedge clk);
    acc_clr = 1'b0;
    checkBoth(t.name, t.y0, t.o0, t.y1, t.o1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    op = 3'd0; a = '0; b = '0; a_signed = '0; b_signed = '0;

    vecs[0] = '{"add_s_u", 3'd0, {6'd31, 6'd10, 6'h3B}, {6'd1, 6'd20, 6'h0E}, 3'b101, 3'b101,
                {6'd32, 6'd30, 6'd9}, 3'b100, {6'd31, 6'd30, 6'd9}, 3'b100};
    vecs[1] = '{"add_ovf", 3'd0, {6'd63, 6'h20, 6'd60}, {6'd0, 6'h3F, 6'd10}, 3'b010, 3'b010,
                {6'd63, 6'd31, 6'd6}, 3'b011, {6'd63, 6'd32, 6'd63}, 3'b011};
    vecs[2] = '{"sub", 3'd1, {6'd10, 6'h20, 6'd5}, {6'h3B, 6'd1, 6'd7}, 3'b110, 3'b110,
                {6'd15, 6'd31, 6'd62}, 3'b011, {6'd15, 6'd32, 6'd0}, 3'b011};
    vecs[3] = '{"and", 3'd2, {6'h33, 6'h3F, 6'h2A}, {6'h0C, 6'h15, 6'h0F}, 3'b111, 3'b111,
                {6'h00, 6'h15, 6'h0A}, 3'b000, {6'h00, 6'h15, 6'h0A}, 3'b000};
    vecs[4] = '{"xnor", 3'd3, {6'h3F, 6'h00, 6'h2A}, {6'h3F, 6'h00, 6'h0F}, 3'b000, 3'b000,
                {6'h3F, 6'h3F, 6'h1A}, 3'b000, {6'h3F, 6'h3F, 6'h1A}, 3'b000};
    vecs[5] = '{"cmp_mixed", 3'd4, {6'd3, 6'h3F, 6'h3F}, {6'd4, 6'd1, 6'd1}, 3'b011, 3'b010,
                {6'd1, 6'd1, 6'd0}, 3'b000, {6'd1, 6'd1, 6'd0}, 3'b000};
    vecs[6] = '{"cmp_edge", 3'd4, {6'd5, 6'h20, 6'h20}, {6'd5, 6'h1F, 6'h1F}, 3'b001, 3'b001,
                {6'd0, 6'd0, 6'd1}, 3'b000, {6'd0, 6'd0, 6'd1}, 3'b000};
    vecs[7] = '{"shl", 3'd5, {6'd1, 6'h21, 6'd5}, {6'h0D, 6'd1, 6'd2}, 3'b000, 3'b000,
                {6'd32, 6'd2, 6'd20}, 3'b000, {6'd32, 6'd2, 6'd20}, 3'b000};
    vecs[8] = '{"sar", 3'd6, {6'h20, 6'h30, 6'h30}, {6'h0F, 6'd2, 6'd2}, 3'b101, 3'b000,
                {6'd63, 6'd12, 6'd60}, 3'b000, {6'd63, 6'd12, 6'd60}, 3'b000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst/valid0", 32'(out_valid0), 32'd0);
    checkOutput("rst/valid1", 32'(out_valid1), 32'd0);
    checkOutput("rst/in_ready", 32'({in_ready0, in_ready1}), 32'd3);
    checkOutput("rst/y", 32'({y0s, ovf0s}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], 1'b0);

    // Accumulate 20 four times on ch0, -1 on signed ch1.
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    v = '{"acc1", 3'd7, {6'd0, 6'h3F, 6'd20}, '0, 3'b010, 3'b010,
          {6'd0, 6'd63, 6'd20}, 3'b000, {6'd0, 6'd63, 6'd20}, 3'b000};
    applyStimulus(v, 1'b0);
    v.name = "acc2"; v.y0 = {6'd0, 6'd62, 6'd40}; v.y1 = v.y0;
    applyStimulus(v, 1'b0);
    v.name = "acc3"; v.y0 = {6'd0, 6'd61, 6'd60}; v.y1 = v.y0;
    applyStimulus(v, 1'b0);
    v.name = "acc4"; v.y0 = {6'd0, 6'd60, 6'd16}; v.o0 = 3'b001;
    v.y1 = {6'd0, 6'd60, 6'd63}; v.o1 = 3'b001;
    applyStimulus(v, 1'b0);
    v = '{"acc_clr_add", 3'd7, {6'd0, 6'd1, 6'd5}, '0, 3'b010, 3'b010,
          {6'd0, 6'd1, 6'd5}, 3'b000, {6'd0, 6'd1, 6'd5}, 3'b000};
    applyStimulus(v, 1'b1);

    // Backpressure: A and B in flight, C offered while stalled must be ignored.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; a = {6'd0, 6'd0, 6'd1}; b = {6'd0, 6'd0, 6'd2};
    a_signed = '0; b_signed = '0;
    @(posedge clk);
    @(negedge clk);
    op = 3'd1; a = {6'd0, 6'd0, 6'd9}; b = {6'd0, 6'd0, 6'd4};
    @(posedge clk);
    @(negedge clk);
    op = 3'd0; a = {6'd0, 6'd0, 6'd7}; b = {6'd0, 6'd0, 6'd7};
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp/in_ready", 32'({in_ready0, in_ready1}), 32'd0);
      checkBoth("bp/holdA", {6'd0, 6'd0, 6'd3}, 3'b000, {6'd0, 6'd0, 6'd3}, 3'b000);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkBoth("bp/B", {6'd0, 6'd0, 6'd5}, 3'b000, {6'd0, 6'd0, 6'd5}, 3'b000);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp/drain0", 32'(out_valid0), 32'd0);
    checkOutput("bp/drain1", 32'(out_valid1), 32'd0);

    // Reset with both stages full and a nonzero accumulator.
    in_valid = 1'b1; op = 3'd7; a = {6'd0, 6'd0, 6'd9}; b = '0;
    @(posedge clk);
    @(negedge clk);
    op = 3'd0; a = {6'd0, 6'd0, 6'd1}; b = {6'd0, 6'd0, 6'd1};
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst/valid", 32'({out_valid0, out_valid1}), 32'd0);
    checkOutput("mid_rst/y", 32'({y0s, y1s}), 32'd0);
    checkOutput("mid_rst/ovf", 32'({ovf0s, ovf1s}), 32'd0);
    checkOutput("mid_rst/in_ready", 32'({in_ready0, in_ready1}), 32'd3);
    rst = 1'b0;
    v = '{"post_rst_acc", 3'd7, {6'd0, 6'd0, 6'd3}, '0, 3'b000, 3'b000,
          {6'd0, 6'd0, 6'd3}, 3'b000, {6'd0, 6'd0, 6'd3}, 3'b000};
    applyStimulus(v, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst/bubble", 32'({out_valid0, out_valid1}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
